// File: rtl/sdr_burst_rd_fsm_if.sv
// -----------------------------------------------------------------------------
// sdr_burst_rd_fsm_if
// Request/response and SDRAM-side bus bundle for the burst read sequencer.
//   rd_en   : read request (sampled by the sequencer only while idle)
//   row     : row address           col : column address      ba : bank
//   rd_busy : request in flight     rd_done : one-cycle completion pulse
//   rdata   : assembled burst, beat0 in the low DQ_W bits
//   rd_bus  : {cmd[3:0], a[ROW_W-1:0], ba[1:0], cke} toward the bus arbiter
//   sdr_dq  : SDRAM read data
// Modports: master = requester / SDRAM side, slave = sequencer.
// -----------------------------------------------------------------------------
interface sdr_burst_rd_fsm_if #(
    parameter int unsigned DQ_W      = 16,
    parameter int unsigned BURST_LEN = 2,
    parameter int unsigned ROW_W     = 13,
    parameter int unsigned COL_W     = 10
);
    logic                      rd_en;
    logic [ROW_W-1:0]          row;
    logic [COL_W-1:0]          col;
    logic [1:0]                ba;
    logic                      rd_busy;
    logic                      rd_done;
    logic [DQ_W*BURST_LEN-1:0] rdata;
    logic [ROW_W+6:0]          rd_bus;
    logic [DQ_W-1:0]           sdr_dq;

    modport master (
        output rd_en, row, col, ba, sdr_dq,
        input  rd_busy, rd_done, rdata, rd_bus
    );

    modport slave (
        input  rd_en, row, col, ba, sdr_dq,
        output rd_busy, rd_done, rdata, rd_bus
    );
endinterface

// File: rtl/sdr_burst_rd_fsm.sv
// -----------------------------------------------------------------------------
// sdr_burst_rd_fsm
// SDRAM read sequencer: ACT -> tRCD -> READ -> CAS latency -> burst capture,
// assembling BURST_LEN beats of DQ_W into one rdata word.
// Ports:
//   clk      : system clock
//   soft_rst : asynchronous reset, active-high
//   bus      : sdr_burst_rd_fsm_if.slave (request, rdata, rd_bus, sdr_dq)
// Optional feature macro: RD_AUTO_PRE_EN
//   defined   -> READ issued with A10=1 (auto-precharge), no PRE state
//   undefined -> READ with A10=0, followed by an explicit PRE and T_RP wait
// -----------------------------------------------------------------------------
`ifndef NOP
`define NOP 4'b0111
`endif
`ifndef ACT
`define ACT 4'b0011
`endif
`ifndef RD
`define RD  4'b0101
`endif
`ifndef PRE
`define PRE 4'b0010
`endif

module sdr_burst_rd_fsm #(
    parameter int unsigned DQ_W       = 16,
    parameter int unsigned BURST_LEN  = 2,
    parameter int unsigned ROW_W      = 13,
    parameter int unsigned COL_W      = 10,
    parameter int unsigned T_RCD      = 3,
    parameter int unsigned CAS_LAT    = 3,
    parameter int unsigned CAP_STAGES = 2,
    parameter int unsigned T_RP       = 3
) (
    input logic                clk,
    input logic                soft_rst,
    sdr_burst_rd_fsm_if.slave  bus
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned WORD_W   = DQ_W * BURST_LEN;
    // Cycles between the READ cycle and the first beat leaving the capture chain
    localparam int unsigned CL_CYC   = CAS_LAT + CAP_STAGES - 1;
    localparam int unsigned MAX_WAIT = max2(max2(T_RCD - 1, CL_CYC - 1),
                                            max2(BURST_LEN - 1, T_RP - 1));
    localparam int unsigned CNT_W    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    // Elaboration-time parameter legality
    generate
        if (!(BURST_LEN == 1 || BURST_LEN == 2 || BURST_LEN == 4 || BURST_LEN == 8)) begin : g_bad_burst
            $error("sdr_burst_rd_fsm: BURST_LEN must be 1, 2, 4 or 8");
        end
        if (CAS_LAT != 2 && CAS_LAT != 3) begin : g_bad_cl
            $error("sdr_burst_rd_fsm: CAS_LAT must be 2 or 3");
        end
        if (T_RCD < 1 || CAP_STAGES < 1 || T_RP < 1) begin : g_bad_timing
            $error("sdr_burst_rd_fsm: T_RCD, CAP_STAGES and T_RP must be >= 1");
        end
        if (COL_W > 10 || ROW_W < 11) begin : g_bad_addr
            $error("sdr_burst_rd_fsm: need COL_W <= 10 and ROW_W >= 11 to keep A10 free");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACT_WAIT,
        ST_RD,
        ST_CL_WAIT,
        ST_BURST,
        ST_PRE,
        ST_DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [COL_W-1:0]  col_q;
    logic [1:0]        ba_q;
    logic [3:0]        rd_cmd;
    logic [ROW_W-1:0]  rd_a;
    logic [1:0]        rd_ba;
    logic              rd_busy_q;
    logic              rd_done_q;
    logic [WORD_W-1:0] rdata_q;
    logic [WORD_W-1:0] burst_q;
    logic [DQ_W-1:0]   cap_q [CAP_STAGES];

    logic [DQ_W-1:0]   cap_out_c;
    logic [ROW_W-1:0]  rd_addr_c;
    logic [WORD_W-1:0] burst_nxt_c;

    assign cap_out_c = cap_q[CAP_STAGES-1];

    // READ address: column in the low bits, A10 selects auto-precharge
    always_comb begin
        rd_addr_c              = '0;
        rd_addr_c[COL_W-1:0]   = col_q;
`ifdef RD_AUTO_PRE_EN
        rd_addr_c[10]          = 1'b1;
`else
        rd_addr_c[10]          = 1'b0;
`endif
    end

    // Assembly word with the current beat merged into its slot
    always_comb begin
        burst_nxt_c = burst_q;
        for (int k = 0; k < int'(BURST_LEN); k++) begin
            if (cnt == CNT_W'(k)) begin
                burst_nxt_c[k*DQ_W +: DQ_W] = cap_out_c;
            end
        end
    end

    // DQ capture chain
    always_ff @(posedge clk or posedge soft_rst) begin
        if (soft_rst) begin
            for (int i = 0; i < int'(CAP_STAGES); i++) begin
                cap_q[i] <= '0;
            end
        end else begin
            cap_q[0] <= bus.sdr_dq;
            for (int i = 1; i < int'(CAP_STAGES); i++) begin
                cap_q[i] <= cap_q[i-1];
            end
        end
    end

    // Sequencer; command/address default to NOP/0 and are overridden on state entry
    always_ff @(posedge clk or posedge soft_rst) begin
        if (soft_rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            col_q     <= '0;
            ba_q      <= '0;
            rd_cmd    <= `NOP;
            rd_a      <= '0;
            rd_ba     <= '0;
            rd_busy_q <= 1'b0;
            rd_done_q <= 1'b0;
            rdata_q   <= '0;
            burst_q   <= '0;
        end else begin
            rd_cmd    <= `NOP;
            rd_a      <= '0;
            rd_ba     <= '0;
            rd_done_q <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (bus.rd_en) begin
                        col_q     <= bus.col;
                        ba_q      <= bus.ba;
                        rd_cmd    <= `ACT;
                        rd_a      <= bus.row;
                        rd_ba     <= bus.ba;
                        rd_busy_q <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_ACT_WAIT;
                    end
                end

                // ACT cycle plus T_RCD-1 NOPs
                ST_ACT_WAIT: begin
                    if (cnt == CNT_W'(T_RCD - 1)) begin
                        rd_cmd <= `RD;
                        rd_a   <= rd_addr_c;
                        rd_ba  <= ba_q;
                        cnt    <= '0;
                        state  <= ST_RD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_RD: begin
                    cnt   <= '0;
                    state <= ST_CL_WAIT;
                end

                // Wait until beat0 reaches the end of the capture chain
                ST_CL_WAIT: begin
                    if (cnt == CNT_W'(CL_CYC - 1)) begin
                        cnt   <= '0;
                        state <= ST_BURST;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // One beat per cycle; rdata only changes once the word is complete
                ST_BURST: begin
                    burst_q <= burst_nxt_c;
                    if (cnt == CNT_W'(BURST_LEN - 1)) begin
                        rdata_q <= burst_nxt_c;
                        cnt     <= '0;
`ifdef RD_AUTO_PRE_EN
                        rd_done_q <= 1'b1;
                        rd_busy_q <= 1'b0;
                        state     <= ST_DONE;
`else
                        rd_cmd <= `PRE;
                        rd_a   <= '0;
                        rd_ba  <= ba_q;
                        state  <= ST_PRE;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // PRE cycle plus T_RP-1 NOPs
                ST_PRE: begin
                    if (cnt == CNT_W'(T_RP - 1)) begin
                        cnt       <= '0;
                        rd_done_q <= 1'b1;
                        rd_busy_q <= 1'b0;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // rd_en is not sampled here; next accept is from IDLE
                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state     <= ST_IDLE;
                    rd_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_bus  = {rd_cmd, rd_a, rd_ba, 1'b1};
    assign bus.rd_busy = rd_busy_q;
    assign bus.rd_done = rd_done_q;
    assign bus.rdata   = rdata_q;

endmodule
